// File: rtl/divisor_secuencial.sv
// Multi-cycle restoring shift-subtract divider for DIV/DIVU.
// One quotient bit per clock; quotient to LO, remainder to HI.
module divisor_secuencial #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic             SIGNED,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic             DIV0,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] HI
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] a_raw;
   logic [CW-1:0]    cnt;
   logic             q_neg;
   logic             r_neg;
   logic             div0_f;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;

   // Operand magnitudes and one restoring step; rem is widened so a large divisor cannot overflow the shift.
   always_comb begin
      a_mag  = (SIGNED && A[WIDTH-1]) ? (WIDTH'(0) - A) : A;
      b_mag  = (SIGNED && B[WIDTH-1]) ? (WIDTH'(0) - B) : B;
      rem_sh = {rem, dvd[WIDTH-1]};
      trial  = rem_sh - {1'b0, dvs};
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state  <= IDLE;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         DIV0   <= 1'b0;
         LO     <= '0;
         HI     <= '0;
         dvd    <= '0;
         dvs    <= '0;
         rem    <= '0;
         a_raw  <= '0;
         cnt    <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         div0_f <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  BUSY   <= 1'b1;
                  a_raw  <= A;
                  dvd    <= a_mag;
                  dvs    <= b_mag;
                  rem    <= '0;
                  cnt    <= '0;
                  q_neg  <= SIGNED && (A[WIDTH-1] ^ B[WIDTH-1]);
                  r_neg  <= SIGNED && A[WIDTH-1];
                  div0_f <= (B == '0);
                  state  <= (B == '0) ? FIX : RUN;
               end
            end
            RUN: begin
               // Quotient bits shift into the dividend register as it empties.
               rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
               dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (div0_f) begin
                  LO <= '1;
                  HI <= a_raw;
               end else begin
                  LO <= q_neg ? (WIDTH'(0) - dvd) : dvd;
                  HI <= r_neg ? (WIDTH'(0) - rem) : rem;
               end
               DIV0  <= div0_f;
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/divisor_secuencial.md
# divisor_secuencial

Multi-cycle 32-bit integer divider for the MIPS datapath, executing DIV and DIVU. It is the subtractive counterpart to the combinational SUMADOR. It runs a restoring shift-subtract algorithm, one quotient bit per clock, and writes the quotient to LO and the remainder to HI. The control unit starts it with a one-cycle handshake and stalls mflo/mfhi until DONE.

## Interface
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  synchronous reset, active-low; sampled on the rising edge of CLK.
- START  input  1  request pulse; accepted only in IDLE.
- SIGNED  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with START.
- A  input  WIDTH  dividend (rs); sampled with START.
- B  input  WIDTH  divisor (rt); sampled with START.
- BUSY  output  1  high from the accept edge until the result edge.
- DONE  output  1  one-cycle pulse; HI/LO are valid from this cycle onward.
- DIV0  output  1  valid with DONE; 1 = divisor was zero.
- LO  output  WIDTH  quotient register.
- HI  output  WIDTH  remainder register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, START=1, B≠0: latch |A| and |B| (magnitudes when SIGNED=1, raw values otherwise), latch the quotient/remainder sign flags, clear partial remainder and counter, go to RUN.
- IDLE, START=1, B=0: go directly to FIX with the div-by-zero flag set.
- RUN, each cycle:
  - Shift {rem, dividend} left by 1.
  - Trial = rem − divisor, computed at WIDTH+1 bits.
  - If trial ≥ 0: rem ← trial and shift 1 into the quotient; otherwise shift in 0.
  - Counter increments; after WIDTH iterations go to FIX.
- FIX:
  - Quotient is negated when SIGNED and sign(A)≠sign(B).
  - Remainder is negated when SIGNED and A is negative.
  - Register both into LO/HI, pulse DONE, return to IDLE.
- Division by zero: LO=all ones, HI=A unmodified, DIV0=1.
- Signed overflow, A=0x80000000 with B=0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of WIDTH-bit magnitude arithmetic with no special case.
- All arithmetic is unsigned on magnitudes. |0x80000000| is represented as 0x80000000 unsigned.
- START while BUSY is ignored; no queuing, and in-flight operands are unaffected.
- HI/LO hold their values between operations. They change only on the FIX edge or on reset.

## Timing
- Reset (RESET_N=0 at an edge): state IDLE; BUSY=0, DONE=0, DIV0=0, LO=0, HI=0, counter=0. Reset has priority over every other event, including mid-RUN and FIX.
- Accept edge k (IDLE, START=1): BUSY=1 from after edge k.
- Normal case: RUN covers edges k+1..k+WIDTH. The FIX edge is k+WIDTH+1, i.e. k+33 for WIDTH=32.
- Div-by-zero case: the FIX edge is k+1.
- On the FIX edge: LO/HI/DIV0 update, DONE=1 for exactly that cycle, BUSY=0.
- Back-to-back: START may be asserted in the same cycle DONE is high. That START is accepted at the next edge, giving zero idle gap.
- SIGNED/A/B are don't-care except in the cycle where START is accepted.

## Test plan
- Reset: hold RESET_N=0 for 2 edges, then release → BUSY=0, DONE=0, LO=HI=0.
- DIVU 100/7: START at edge k → BUSY for 33 cycles; DONE after edge k+33 with LO=14, HI=2, DIV0=0.
- DIV −7/2 (A=0xFFFFFFF9, B=2, SIGNED=1) → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/−2 → LO=0xFFFFFFFD, HI=1.
- Boundaries:
  - DIVU 5/0 → DONE after edge k+1, LO=0xFFFFFFFF, HI=5, DIV0=1.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 0xFFFFFFFF/1 → LO=0xFFFFFFFF, HI=0.
- Handshake:
  - START pulsed again at k+10 with different operands → ignored; first result unchanged at k+33.
  - START held during the DONE cycle → second op accepted, its DONE follows 33 edges later.
- Reset mid-operation: RESET_N=0 at edge k+15 → IDLE next cycle, BUSY=0, LO=HI=0, no DONE. A fresh DIVU 9/3 then yields LO=3, HI=0.
